// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported synchronous RAM between the instruction-fetch port
// and the MEM-stage data port. At most one access is granted per cycle, the
// loser is stalled, and read data is steered back one cycle after the grant.
// Data normally wins a conflict so MEM drains before IF, but a fetch that keeps
// requesting is forced through after MAX_DM_RUN consecutive data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_DM_RUN = 4     // legal range 1..15 (4-bit run counter)
) (
    input  logic              clk,
    input  logic              reset,

    // instruction-fetch requester (read only)
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_stall,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,

    // MEM-stage data requester
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [2:0]        dm_type,
    output logic              dm_stall,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,

    // shared memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_type,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Which requester owns the response arriving from the RAM this cycle.
    typedef enum logic [1:0] {
        GR_NONE  = 2'd0,
        GR_IF    = 2'd1,
        GR_DM_RD = 2'd2,
        GR_DM_WR = 2'd3
    } grant_e;

    localparam logic [3:0] MAX_RUN = 4'(MAX_DM_RUN);

    grant_e     last_grant_q, last_grant_d;
    logic [3:0] dm_run_q, dm_run_d;
    logic       run_full;
    logic       grant_if;
    logic       grant_dm;

    // Fetch gets forced through once data has had its full run.
    assign run_full = (dm_run_q == MAX_RUN);

    // Grant decision: data by default on conflict, fetch when the run is used up.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (!reset) begin
            if (if_req && (!dm_req || run_full)) begin
                grant_if = 1'b1;
            end else if (dm_req) begin
                grant_dm = 1'b1;
            end
        end
    end

    // Stall whoever asked but lost; nobody stalls while reset holds the port idle.
    always_comb begin
        if_stall = if_req & ~grant_if & ~reset;
        dm_stall = dm_req & ~grant_dm & ~reset;
    end

    // Run counter only tracks data grants that actually kept a fetch waiting.
    always_comb begin
        dm_run_d = dm_run_q;
        if (grant_if || !if_req) begin
            dm_run_d = '0;
        end else if (grant_dm && !run_full) begin
            dm_run_d = dm_run_q + 4'd1;
        end
    end

    // Remember the kind of access granted so its response can be routed next cycle.
    always_comb begin
        last_grant_d = GR_NONE;
        if (grant_if) begin
            last_grant_d = GR_IF;
        end else if (grant_dm) begin
            last_grant_d = dm_we ? GR_DM_WR : GR_DM_RD;
        end
    end

    // State registers; reset idles the port and forgets any pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GR_NONE;
            dm_run_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            dm_run_q     <= dm_run_d;
        end
    end

    // Memory port mux; everything is zero when no access is granted.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_type  = 3'b000;
        if (grant_if) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (grant_dm) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            mem_type  = dm_type;
        end
    end

    // Response steering. A reset in the response cycle drops the response,
    // so the valids are masked by reset as well as by the recorded grant.
    always_comb begin
        if_valid = ~reset & (last_grant_q == GR_IF);
        dm_valid = ~reset & ((last_grant_q == GR_DM_RD) || (last_grant_q == GR_DM_WR));
        if_rdata = '0;
        dm_rdata = '0;
        if (!reset && last_grant_q == GR_IF) begin
            if_rdata = mem_rdata;
        end
        if (!reset && last_grant_q == GR_DM_RD) begin
            dm_rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run checked
// against a request-level model of the arbitration and a RAM responder.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXR = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_stall, if_valid;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [2:0]    dm_type;
    logic          dm_stall, dm_valid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_type;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] ram [logic [AW-1:0]];

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DM_RUN(MAXR)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_type(dm_type), .dm_stall(dm_stall), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_type(mem_type), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
        if (ram.exists(a)) return ram[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Synchronous single-port RAM; garbage on the read bus when nothing was read.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= ram_rd(mem_addr);
        else                   mem_rdata <= $urandom;
        if (mem_en && mem_we)  ram[mem_addr] = mem_wdata;
    end

    task automatic idle_cycle();
        @(negedge clk);
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h40; dm_addr = 32'h80; dm_we = 1'b0;
        #1;
        n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
        n_checks++; if (if_stall !== 1'b0) begin n_errors++; $display("FAIL reset_if_stall got=%b exp=0", if_stall); end
        n_checks++; if (dm_stall !== 1'b0) begin n_errors++; $display("FAIL reset_dm_stall got=%b exp=0", dm_stall); end
        n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL reset_if_valid got=%b exp=0", if_valid); end
        @(negedge clk);
        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        #1;
        n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL post_reset_if_valid got=%b exp=0", if_valid); end
        n_checks++; if (dm_valid !== 1'b0) begin n_errors++; $display("FAIL post_reset_dm_valid got=%b exp=0", dm_valid); end
        n_checks++; if (if_rdata !== '0) begin n_errors++; $display("FAIL post_reset_if_rdata got=%h exp=0", if_rdata); end
        n_checks++; if (dm_rdata !== '0) begin n_errors++; $display("FAIL post_reset_dm_rdata got=%h exp=0", dm_rdata); end
        n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL post_reset_mem_en got=%b exp=0", mem_en); end
    endtask

    task automatic test_fetch();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b0;
        #1;
        n_checks++; if (mem_en !== 1'b1) begin n_errors++; $display("FAIL fetch_mem_en got=%b exp=1", mem_en); end
        n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL fetch_mem_we got=%b exp=0", mem_we); end
        n_checks++; if (mem_addr !== 32'h10) begin n_errors++; $display("FAIL fetch_mem_addr got=%h exp=10", mem_addr); end
        n_checks++; if (if_stall !== 1'b0) begin n_errors++; $display("FAIL fetch_if_stall got=%b exp=0", if_stall); end
        @(posedge clk); #1;
        n_checks++; if (if_valid !== 1'b1) begin n_errors++; $display("FAIL fetch_if_valid got=%b exp=1", if_valid); end
        n_checks++; if (if_rdata !== 32'h0050_0093) begin n_errors++; $display("FAIL fetch_if_rdata got=%h exp=00500093", if_rdata); end
        n_checks++; if (dm_valid !== 1'b0) begin n_errors++; $display("FAIL fetch_dm_valid got=%b exp=0", dm_valid); end
    endtask

    task automatic test_write_then_fetch();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h14;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_type = 3'b000;
        #1;
        n_checks++; if (mem_we !== 1'b1) begin n_errors++; $display("FAIL wr_mem_we got=%b exp=1", mem_we); end
        n_checks++; if (mem_addr !== 32'h100) begin n_errors++; $display("FAIL wr_mem_addr got=%h exp=100", mem_addr); end
        n_checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL wr_mem_wdata got=%h exp=deadbeef", mem_wdata); end
        n_checks++; if (if_stall !== 1'b1) begin n_errors++; $display("FAIL wr_if_stall got=%b exp=1", if_stall); end
        n_checks++; if (dm_stall !== 1'b0) begin n_errors++; $display("FAIL wr_dm_stall got=%b exp=0", dm_stall); end
        @(posedge clk); #1;
        n_checks++; if (dm_valid !== 1'b1) begin n_errors++; $display("FAIL wr_dm_valid got=%b exp=1", dm_valid); end
        n_checks++; if (dm_rdata !== '0) begin n_errors++; $display("FAIL wr_dm_rdata got=%h exp=0", dm_rdata); end
        n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL wr_if_valid got=%b exp=0", if_valid); end
        @(negedge clk);
        dm_req = 1'b0; dm_we = 1'b0;
        #1;
        n_checks++; if (mem_addr !== 32'h14) begin n_errors++; $display("FAIL wr_then_fetch_addr got=%h exp=14", mem_addr); end
        n_checks++; if (if_stall !== 1'b0) begin n_errors++; $display("FAIL wr_then_fetch_stall got=%b exp=0", if_stall); end
        @(posedge clk); #1;
        n_checks++; if (if_valid !== 1'b1) begin n_errors++; $display("FAIL wr_then_fetch_valid got=%b exp=1", if_valid); end
        n_checks++; if (if_rdata !== (32'h14 ^ 32'hA5A5_5A5A)) begin n_errors++; $display("FAIL wr_then_fetch_rdata got=%h exp=%h", if_rdata, 32'h14 ^ 32'hA5A5_5A5A); end
    endtask

    task automatic test_data_read();
        @(negedge clk);
        if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_type = 3'b010;
        #1;
        n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin n_errors++; $display("FAIL rd_mem_en_we got=%b%b exp=10", mem_en, mem_we); end
        n_checks++; if (mem_addr !== 32'h200) begin n_errors++; $display("FAIL rd_mem_addr got=%h exp=200", mem_addr); end
        n_checks++; if (mem_type !== 3'b010) begin n_errors++; $display("FAIL rd_mem_type got=%b exp=010", mem_type); end
        @(posedge clk); #1;
        n_checks++; if (dm_valid !== 1'b1) begin n_errors++; $display("FAIL rd_dm_valid got=%b exp=1", dm_valid); end
        n_checks++; if (dm_rdata !== 32'h1234_5678) begin n_errors++; $display("FAIL rd_dm_rdata got=%h exp=12345678", dm_rdata); end
        n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL rd_if_valid got=%b exp=0", if_valid); end
        n_checks++; if (if_rdata !== '0) begin n_errors++; $display("FAIL rd_if_rdata got=%h exp=0", if_rdata); end
    endtask

    task automatic test_fairness();
        bit exp_if;
        idle_cycle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h300;
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
            #1;
            exp_if = ((i % (MAXR + 1)) == MAXR);
            n_checks++; if (mem_addr !== (exp_if ? 32'h300 : 32'h400)) begin n_errors++; $display("FAIL fair_grant[%0d] addr got=%h exp_if=%b", i, mem_addr, exp_if); end
            n_checks++; if (if_stall !== !exp_if) begin n_errors++; $display("FAIL fair_if_stall[%0d] got=%b exp=%b", i, if_stall, !exp_if); end
            n_checks++; if (dm_stall !== exp_if) begin n_errors++; $display("FAIL fair_dm_stall[%0d] got=%b exp=%b", i, dm_stall, exp_if); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_drop();
        idle_cycle();
        // fetch granted, then reset lands on its response cycle
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL drop_if_valid got=%b exp=0", if_valid); end
        n_checks++; if (if_rdata !== '0) begin n_errors++; $display("FAIL drop_if_rdata got=%h exp=0", if_rdata); end
        n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL drop_mem_en got=%b exp=0", mem_en); end
        n_checks++; if (if_stall !== 1'b0) begin n_errors++; $display("FAIL drop_if_stall got=%b exp=0", if_stall); end
        @(negedge clk);
        reset = 1'b0; if_req = 1'b0;
        #1;
        n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL drop_after_if_valid got=%b exp=0", if_valid); end
        // build a partial data run, then check reset cleared it
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h500; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600;
            @(posedge clk); #1;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_checks++; if (if_stall !== (i < MAXR)) begin n_errors++; $display("FAIL run_cleared_if_stall[%0d] got=%b exp=%b", i, if_stall, (i < MAXR)); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        int  streak = 0;
        int  dut_wait = 0;
        bit  prev_if_stall = 1'b0, prev_dm_stall = 1'b0;
        bit  g_if, g_dm;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_rd;
        idle_cycle();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!(prev_if_stall && $urandom_range(0, 7) != 0)) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = AW'($urandom_range(0, 63)) << 2;
            end
            if (!(prev_dm_stall && $urandom_range(0, 7) != 0)) begin
                dm_req   = ($urandom_range(0, 4) < 3);
                dm_we    = $urandom_range(0, 1) == 1;
                dm_addr  = AW'($urandom_range(0, 63)) << 2;
                dm_wdata = $urandom;
                dm_type  = 3'($urandom_range(0, 7));
            end
            #1;
            g_if     = if_req && (!dm_req || streak == MAXR);
            g_dm     = dm_req && !g_if;
            exp_addr = g_if ? if_addr : (g_dm ? dm_addr : '0);
            exp_rd   = ram_rd(exp_addr);
            n_checks++; if (mem_en !== (g_if || g_dm)) begin n_errors++; $display("FAIL rnd_mem_en[%0d] got=%b exp=%b", c, mem_en, g_if || g_dm); end
            n_checks++; if (mem_addr !== exp_addr) begin n_errors++; $display("FAIL rnd_mem_addr[%0d] got=%h exp=%h", c, mem_addr, exp_addr); end
            n_checks++; if (mem_we !== (g_dm && dm_we)) begin n_errors++; $display("FAIL rnd_mem_we[%0d] got=%b exp=%b", c, mem_we, g_dm && dm_we); end
            n_checks++; if (mem_wdata !== (g_dm ? dm_wdata : '0)) begin n_errors++; $display("FAIL rnd_mem_wdata[%0d] got=%h", c, mem_wdata); end
            n_checks++; if (mem_type !== (g_dm ? dm_type : 3'b000)) begin n_errors++; $display("FAIL rnd_mem_type[%0d] got=%b", c, mem_type); end
            n_checks++; if (if_stall !== (if_req && !g_if)) begin n_errors++; $display("FAIL rnd_if_stall[%0d] got=%b exp=%b", c, if_stall, if_req && !g_if); end
            n_checks++; if (dm_stall !== (dm_req && !g_dm)) begin n_errors++; $display("FAIL rnd_dm_stall[%0d] got=%b exp=%b", c, dm_stall, dm_req && !g_dm); end
            dut_wait = (if_stall === 1'b1) ? dut_wait + 1 : 0;
            n_checks++; if (dut_wait > MAXR) begin n_errors++; $display("FAIL rnd_fairness[%0d] waited=%0d max=%0d", c, dut_wait, MAXR); end
            if (g_if || !if_req) streak = 0;
            else if (g_dm && streak < MAXR) streak++;
            prev_if_stall = if_req && !g_if;
            prev_dm_stall = dm_req && !g_dm;
            @(posedge clk); #1;
            n_checks++; if (if_valid !== g_if) begin n_errors++; $display("FAIL rnd_if_valid[%0d] got=%b exp=%b", c, if_valid, g_if); end
            n_checks++; if (dm_valid !== g_dm) begin n_errors++; $display("FAIL rnd_dm_valid[%0d] got=%b exp=%b", c, dm_valid, g_dm); end
            n_checks++; if (if_rdata !== (g_if ? exp_rd : '0)) begin n_errors++; $display("FAIL rnd_if_rdata[%0d] got=%h exp=%h", c, if_rdata, g_if ? exp_rd : '0); end
            n_checks++; if (dm_rdata !== ((g_dm && !dm_we) ? exp_rd : '0)) begin n_errors++; $display("FAIL rnd_dm_rdata[%0d] got=%h exp=%h", c, dm_rdata, (g_dm && !dm_we) ? exp_rd : '0); end
        end
    endtask

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_type = 3'b000;
        ram[32'h10]  = 32'h0050_0093;
        ram[32'h200] = 32'h1234_5678;
        test_reset();
        test_fetch();
        test_write_then_fetch();
        test_data_read();
        test_fairness();
        test_reset_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
